// File: rtl/jailbreak_hs_pkg.sv
// -----------------------------------------------------------------------------
// jailbreak_hs_pkg
// Shared types for the JailBreak high-score engine: FSM state encoding,
// region table entry layout and transfer direction codes.
// Build option: define HS_CHECKSUM_EN to append an 8-bit sum byte after the
// last region on save and to verify it on restore.
// -----------------------------------------------------------------------------
package jailbreak_hs_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ACQ,
      SEEK,
      RADDR,
      RWAIT,
      TXOUT,
      RXIN,
      WSTB,
      NEXT,
      CSUM,
      REL
   } state_e;

   typedef struct packed {
      logic [15:0] start;
      logic [7:0]  len;
   } region_t;

   localparam logic DIR_SAVE = 1'b0;
   localparam logic DIR_REST = 1'b1;

`ifdef HS_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

endpackage

// File: rtl/hs_region_table.sv
// -----------------------------------------------------------------------------
// hs_region_table
// NREG-entry register file of work-RAM regions {start, len}. One synchronous
// write port, one combinational read port.
// Ports:
//   clk48M, reset_n   clock, asynchronous active-low reset
//   we_i              write enable
//   wr_idx_i          write index
//   wr_data_i         entry to write
//   rd_idx_i          read index
//   rd_data_o         entry at rd_idx_i
// -----------------------------------------------------------------------------
module hs_region_table
   import jailbreak_hs_pkg::*;
#(
   parameter int NREG  = 8,
   parameter int IDX_W = $clog2(NREG)
) (
   input  logic             clk48M,
   input  logic             reset_n,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  region_t          wr_data_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output region_t          rd_data_o
);

   region_t regs_q [NREG];

   // NOTE: this table is reset on purpose: a cleared entry (len 0) means
   // "disabled", so stale contents after reset would trigger spurious transfers.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk48M or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_o = regs_q[rd_idx_i];

endmodule

// File: rtl/jailbreak_hiscore_engine.sv
// -----------------------------------------------------------------------------
// jailbreak_hiscore_engine
// Initiator on the core's high-score RAM port. On start_save it walks every
// enabled region, reads each byte from the core and streams it to the host;
// on start_rest it takes host bytes and writes them back into the core.
// Build option: HS_CHECKSUM_EN adds a trailing 8-bit sum byte (sent on save,
// verified on restore with a sticky err); undefined, err is tied low.
// Ports:
//   clk48M, reset_n            clock, asynchronous active-low reset
//   cfg_we/idx/start/len       region table write (ignored while busy)
//   start_save, start_rest     1-clock start pulses (save wins on a tie)
//   busy, done, err            status
//   tx_data/valid/ready        save byte stream to host
//   rx_data/valid/ready        restore byte stream from host
//   hs_address/wdata/rdata     core high-score RAM port
//   hs_write, hs_access        write strobe, port ownership
// -----------------------------------------------------------------------------
module jailbreak_hiscore_engine
   import jailbreak_hs_pkg::*;
#(
   parameter int NREG   = 8,
   parameter int RD_LAT = 2,
   parameter int SETUP  = 4
) (
   input  logic        clk48M,
   input  logic        reset_n,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_idx,
   input  logic [15:0] cfg_start,
   input  logic [7:0]  cfg_len,
   input  logic        start_save,
   input  logic        start_rest,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [15:0] hs_address,
   output logic [7:0]  hs_wdata,
   input  logic [7:0]  hs_rdata,
   output logic        hs_write,
   output logic        hs_access
);

   localparam int IDX_W = $clog2(NREG);

   state_e         state_q, state_d;
   logic           dir_q, dir_d;
   logic [IDX_W:0] idx_q, idx_d;   // one extra bit so it can reach NREG
   logic [7:0]     ofs_q, ofs_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [7:0]     data_q, data_d;
   logic [7:0]     sum_q, sum_d;
   logic           err_q, err_d;
   logic           done_q, done_d;

   region_t        region;
   region_t        cfg_entry;
   logic [15:0]    addr;
   logic           last_byte;
   logic           per_byte;

   assign cfg_entry = region_t'{start: cfg_start, len: cfg_len};

   hs_region_table #(
      .NREG  (NREG),
      .IDX_W (IDX_W)
   ) u_table (
      .clk48M    (clk48M),
      .reset_n   (reset_n),
      .we_i      (cfg_we && (state_q == IDLE)),
      .wr_idx_i  (cfg_idx[IDX_W-1:0]),
      .wr_data_i (cfg_entry),
      .rd_idx_i  (idx_q[IDX_W-1:0]),
      .rd_data_o (region)
   );

   // 16-bit add: regions crossing 0xFFFF wrap to 0x0000 by design.
   assign addr      = region.start + {8'h00, ofs_q};
   assign last_byte = (ofs_q == region.len - 8'd1);

   always_ff @(posedge clk48M or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dir_q   <= DIR_SAVE;
         idx_q   <= '0;
         ofs_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         sum_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         idx_q   <= idx_d;
         ofs_q   <= ofs_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      idx_d   = idx_q;
      ofs_d   = ofs_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      sum_d   = sum_q;
      err_d   = err_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_save || start_rest) begin
               dir_d   = start_save ? DIR_SAVE : DIR_REST;
               idx_d   = '0;
               ofs_d   = '0;
               cnt_d   = '0;
               sum_d   = '0;
               err_d   = 1'b0;
               state_d = ACQ;
            end
         end
         ACQ: begin
            if (cnt_q == 8'(SETUP - 1)) begin
               cnt_d   = '0;
               state_d = SEEK;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         SEEK: begin
            if (idx_q == (IDX_W + 1)'(NREG)) begin
               cnt_d   = '0;
               state_d = CSUM_EN ? CSUM : REL;
            end else if (region.len == 8'd0) begin
               idx_d = idx_q + 1'b1;
            end else begin
               ofs_d   = '0;
               state_d = (dir_q == DIR_SAVE) ? RADDR : RXIN;
            end
         end
         RADDR: begin
            cnt_d   = '0;
            state_d = RWAIT;
         end
         RWAIT: begin
            // Address has been stable since RADDR; data is valid RD_LAT clocks later.
            if (cnt_q == 8'(RD_LAT - 1)) begin
               data_d  = hs_rdata;
               sum_d   = sum_q + hs_rdata;
               state_d = TXOUT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         TXOUT: begin
            if (tx_ready) begin
               if (last_byte) begin
                  state_d = NEXT;
               end else begin
                  ofs_d   = ofs_q + 8'd1;
                  state_d = RADDR;
               end
            end
         end
         RXIN: begin
            if (rx_valid) begin
               data_d  = rx_data;
               sum_d   = sum_q + rx_data;
               state_d = WSTB;
            end
         end
         WSTB: begin
            if (last_byte) begin
               state_d = NEXT;
            end else begin
               ofs_d   = ofs_q + 8'd1;
               state_d = RXIN;
            end
         end
         NEXT: begin
            idx_d   = idx_q + 1'b1;
            ofs_d   = '0;
            state_d = SEEK;
         end
         CSUM: begin
            cnt_d = '0;
            if (dir_q == DIR_SAVE) begin
               if (tx_ready) state_d = REL;
            end else if (rx_valid) begin
               // Data already written stays written; only the flag records it.
               err_d   = (rx_data != sum_q);
               state_d = REL;
            end
         end
         REL: begin
            if (cnt_q == 8'(SETUP - 1)) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Address is held through the whole byte so a host stall never moves it.
   assign per_byte = (state_q == RADDR) || (state_q == RWAIT) || (state_q == TXOUT) ||
                     (state_q == RXIN)  || (state_q == WSTB);

   // Port ownership decodes straight from the async-reset state register, so
   // hs_access and hs_write fall the moment reset_n is asserted.
   assign busy       = (state_q != IDLE);
   assign hs_access  = (state_q != IDLE);
   assign hs_write   = (state_q == WSTB);
   assign hs_address = per_byte ? addr : 16'h0000;
   assign hs_wdata   = data_q;
   assign done       = done_q;
   assign err        = err_q & CSUM_EN;
   assign tx_valid   = (state_q == TXOUT) || ((state_q == CSUM) && (dir_q == DIR_SAVE));
   assign tx_data    = (state_q == CSUM) ? sum_q : data_q;
   assign rx_ready   = (state_q == RXIN)  || ((state_q == CSUM) && (dir_q == DIR_REST));

endmodule

// File: tb/tb_jailbreak_hiscore_engine.sv
// -----------------------------------------------------------------------------
// tb_jailbreak_hiscore_engine
// Directed bench: a core RAM model (unwritten bytes read back as addr[7:0],
// RD_LAT-deep read pipeline), host-side tx/rx drivers and one task per
// scenario with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_jailbreak_hiscore_engine;

   localparam int RD_LAT = 2;
   localparam int SETUP  = 4;
`ifdef HS_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic        clk48M;
   logic        reset_n;
   logic        cfg_we;
   logic [2:0]  cfg_idx;
   logic [15:0] cfg_start;
   logic [7:0]  cfg_len;
   logic        start_save, start_rest;
   logic        busy, done, err;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_ready;
   logic [15:0] hs_address;
   logic [7:0]  hs_wdata, hs_rdata;
   logic        hs_write, hs_access;

   int n_checks = 0;
   int n_fail   = 0;

   jailbreak_hiscore_engine #(.NREG(8), .RD_LAT(RD_LAT), .SETUP(SETUP)) dut (
      .clk48M     (clk48M),
      .reset_n    (reset_n),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_start  (cfg_start),
      .cfg_len    (cfg_len),
      .start_save (start_save),
      .start_rest (start_rest),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .hs_address (hs_address),
      .hs_wdata   (hs_wdata),
      .hs_rdata   (hs_rdata),
      .hs_write   (hs_write),
      .hs_access  (hs_access)
   );

   initial clk48M = 1'b0;
   always #5 clk48M = ~clk48M;

   // ---------------- core RAM model and monitors ----------------
   logic [7:0]  mem [logic [15:0]];
   logic [7:0]  rd_p1;
   int          cyc = 0;
   logic [7:0]  tx_q [$];
   int          tx_t [$];
   logic [15:0] wr_a [$];
   logic [7:0]  wr_d [$];
   int          done_cnt = 0;

   always @(posedge clk48M) begin
      cyc   <= cyc + 1;
      rd_p1 <= mem.exists(hs_address) ? mem[hs_address] : hs_address[7:0];
      hs_rdata <= rd_p1;
   end

   always @(negedge clk48M) begin
      if (hs_write) begin
         mem[hs_address] = hs_wdata;
         wr_a.push_back(hs_address);
         wr_d.push_back(hs_wdata);
      end
      if (tx_valid && tx_ready) begin
         tx_q.push_back(tx_data);
         tx_t.push_back(cyc);
      end
      if (done) done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk48M);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic cfg(input logic [2:0] i, input logic [15:0] s, input logic [7:0] l);
      cfg_we = 1'b1; cfg_idx = i; cfg_start = s; cfg_len = l;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_save();
      start_save = 1'b1;
      tick();
      start_save = 1'b0;
   endtask

   task automatic pulse_rest();
      start_rest = 1'b1;
      tick();
      start_rest = 1'b0;
   endtask

   // Polls once per clock; done is a one-clock pulse so it cannot be skipped.
   task automatic wait_done(output bit ok, output bit acc_ok);
      ok = 1'b0;
      acc_ok = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (!hs_access) acc_ok = 1'b0;
         tick();
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (rx_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      rx_valid = 1'b0;
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL rx_accept: got no rx_ready for byte %0h, expected acceptance", b);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({busy, done, err, tx_valid, rx_ready, hs_access, hs_write} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, expected 0000000",
                  {busy, done, err, tx_valid, rx_ready, hs_access, hs_write});
      end
      n_checks++;
      if (hs_address !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_addr: got %h, expected 0000", hs_address);
      end
      n_checks++;
      if ({tx_data, hs_wdata} !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_data: got %h, expected 0000", {tx_data, hs_wdata});
      end
   endtask

   task automatic test_save_basic();
      int tb;
      bit ok, acc_ok;
      cfg(3'd0, 16'h8000, 8'd4);
      tx_ready = 1'b1;
      tb = tx_q.size();
      pulse_save();
      n_checks++;
      if ({busy, hs_access} !== 2'b11) begin
         n_fail++;
         $display("FAIL save_start: busy,hs_access got %b, expected 11", {busy, hs_access});
      end
      wait_done(ok, acc_ok);
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL save_done: got timeout, expected done pulse");
      end
      n_checks++;
      if (acc_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL save_access: got hs_access low before done, expected high");
      end
      n_checks++;
      if ({busy, hs_access} !== 2'b00) begin
         n_fail++;
         $display("FAIL save_release: busy,hs_access at done got %b, expected 00", {busy, hs_access});
      end
      n_checks++;
      if (tx_q.size() - tb !== 4 + CS) begin
         n_fail++;
         $display("FAIL save_count: got %0d bytes, expected %0d", tx_q.size() - tb, 4 + CS);
      end
      if (tx_q.size() >= tb + 4) begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tx_q[tb + i] !== 8'(i)) begin
               n_fail++;
               $display("FAIL save_byte%0d: got %h, expected %h", i, tx_q[tb + i], 8'(i));
            end
         end
         n_checks++;
         if (tx_t[tb + 1] - tx_t[tb] !== RD_LAT + 2) begin
            n_fail++;
            $display("FAIL save_rate: got %0d clks/byte, expected %0d",
                     tx_t[tb + 1] - tx_t[tb], RD_LAT + 2);
         end
      end
`ifdef HS_CHECKSUM_EN
      n_checks++;
      if (tx_q[tb + 4] !== 8'h06) begin
         n_fail++;
         $display("FAIL save_csum: got %h, expected 06", tx_q[tb + 4]);
      end
`endif
   endtask

   task automatic test_restore_wrap();
      int wb;
      bit ok, acc_ok;
      logic [23:0] exp_w [3];
      exp_w[0] = {16'hFFFE, 8'hAA};
      exp_w[1] = {16'hFFFF, 8'hBB};
      exp_w[2] = {16'h0000, 8'hCC};
      do_reset();
      cfg(3'd2, 16'hFFFE, 8'd3);
      wb = wr_a.size();
      pulse_rest();
      send_rx(8'hAA);
      send_rx(8'hBB);
      send_rx(8'hCC);
`ifdef HS_CHECKSUM_EN
      send_rx(8'h31);
`endif
      wait_done(ok, acc_ok);
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL rest_done: got timeout, expected done pulse");
      end
      n_checks++;
      if (wr_a.size() - wb !== 3) begin
         n_fail++;
         $display("FAIL rest_wcount: got %0d strobes, expected 3", wr_a.size() - wb);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({wr_a[wb + i], wr_d[wb + i]} !== exp_w[i]) begin
               n_fail++;
               $display("FAIL rest_write%0d: got %h, expected %h", i,
                        {wr_a[wb + i], wr_d[wb + i]}, exp_w[i]);
            end
         end
      end
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL rest_err: got %b, expected 0", err);
      end
   endtask

   task automatic test_stall();
      int tb;
      bit ok, acc_ok, seen, stable;
      logic [15:0] a0;
      logic [7:0]  d0;
      do_reset();
      cfg(3'd0, 16'h8010, 8'd3);
      tx_ready = 1'b0;
      tb = tx_q.size();
      pulse_save();
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (tx_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      a0 = hs_address;
      d0 = tx_data;
      stable = seen;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (tx_valid !== 1'b1 || tx_data !== d0 || hs_address !== a0 || hs_access !== 1'b1)
            stable = 1'b0;
      end
      n_checks++;
      if (stable !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_hold: got unstable or missing tx_valid, expected held for 50 clks");
      end
      n_checks++;
      if ({a0, d0} !== {16'h8010, 8'h10}) begin
         n_fail++;
         $display("FAIL stall_first: got %h, expected 801010", {a0, d0});
      end
      tx_ready = 1'b1;
      wait_done(ok, acc_ok);
      n_checks++;
      if (ok !== 1'b1 || tx_q.size() - tb !== 3 + CS) begin
         n_fail++;
         $display("FAIL stall_count: got %0d bytes, expected %0d", tx_q.size() - tb, 3 + CS);
      end else begin
         n_checks++;
         if ({tx_q[tb], tx_q[tb + 1], tx_q[tb + 2]} !== 24'h101112) begin
            n_fail++;
            $display("FAIL stall_order: got %h, expected 101112",
                     {tx_q[tb], tx_q[tb + 1], tx_q[tb + 2]});
         end
      end
   endtask

   task automatic test_start_conflict();
      int tb, wb, db;
      bit ok, acc_ok;
      do_reset();
      cfg(3'd0, 16'h8020, 8'd2);
      tx_ready = 1'b1;
      tb = tx_q.size();
      wb = wr_a.size();
      db = done_cnt;
      start_save = 1'b1;
      start_rest = 1'b1;
      tick();
      start_save = 1'b0;
      start_rest = 1'b0;
      tick();
      start_rest = 1'b1;
      tick();
      start_rest = 1'b0;
      start_save = 1'b1;
      tick();
      start_save = 1'b0;
      cfg(3'd1, 16'h8040, 8'd5);   // must be ignored: engine is busy
      wait_done(ok, acc_ok);
      repeat (30) tick();
      n_checks++;
      if (done_cnt - db !== 1) begin
         n_fail++;
         $display("FAIL busy_done: got %0d done pulses, expected 1", done_cnt - db);
      end
      n_checks++;
      if (wr_a.size() - wb !== 0) begin
         n_fail++;
         $display("FAIL tie_nowrite: got %0d strobes, expected 0", wr_a.size() - wb);
      end
      n_checks++;
      if (tx_q.size() - tb !== 2 + CS) begin
         n_fail++;
         $display("FAIL tie_save: got %0d bytes, expected %0d", tx_q.size() - tb, 2 + CS);
      end else begin
         n_checks++;
         if ({tx_q[tb], tx_q[tb + 1]} !== 16'h2021) begin
            n_fail++;
            $display("FAIL tie_bytes: got %h, expected 2021", {tx_q[tb], tx_q[tb + 1]});
         end
      end
      tb = tx_q.size();
      pulse_save();
      wait_done(ok, acc_ok);
      n_checks++;
      if (tx_q.size() - tb !== 2 + CS) begin
         n_fail++;
         $display("FAIL cfg_busy: got %0d bytes, expected %0d", tx_q.size() - tb, 2 + CS);
      end
   endtask

   task automatic test_reset_mid();
      int tb;
      bit ok, acc_ok, seen;
      do_reset();
      cfg(3'd0, 16'h8000, 8'd4);
      tx_ready = 1'b1;
      pulse_save();
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (hs_address == 16'h8000) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      tick();                        // now in RWAIT
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({seen, hs_access, hs_write, busy} !== 4'b1000) begin
         n_fail++;
         $display("FAIL rst_async: seen,access,write,busy got %b, expected 1000",
                  {seen, hs_access, hs_write, busy});
      end
      tick();
      reset_n = 1'b1;
      tick();
      n_checks++;
      if ({busy, tx_valid, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_idle: busy,tx_valid,done got %b, expected 000", {busy, tx_valid, done});
      end
      tb = tx_q.size();
      pulse_save();
      wait_done(ok, acc_ok);
      n_checks++;
      if (ok !== 1'b1 || tx_q.size() - tb !== CS) begin
         n_fail++;
         $display("FAIL rst_table: got %0d bytes, expected %0d", tx_q.size() - tb, CS);
      end
`ifdef HS_CHECKSUM_EN
      else begin
         n_checks++;
         if (tx_q[tb] !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_csum: got %h, expected 00", tx_q[tb]);
         end
      end
`endif
   endtask

`ifdef HS_CHECKSUM_EN
   task automatic test_checksum();
      int tb, wb;
      bit ok, acc_ok;
      do_reset();
      cfg(3'd0, 16'h9000, 8'd2);
      pulse_rest();                  // preload 9000=10, 9001=20 through the engine
      send_rx(8'h10);
      send_rx(8'h20);
      send_rx(8'h30);
      wait_done(ok, acc_ok);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL csum_good: err got %b, expected 0", err);
      end
      tx_ready = 1'b1;
      tb = tx_q.size();
      pulse_save();
      wait_done(ok, acc_ok);
      n_checks++;
      if (tx_q.size() - tb !== 3) begin
         n_fail++;
         $display("FAIL csum_count: got %0d bytes, expected 3", tx_q.size() - tb);
      end else begin
         n_checks++;
         if ({tx_q[tb], tx_q[tb + 1], tx_q[tb + 2]} !== 24'h102030) begin
            n_fail++;
            $display("FAIL csum_save: got %h, expected 102030",
                     {tx_q[tb], tx_q[tb + 1], tx_q[tb + 2]});
         end
      end
      wb = wr_a.size();
      pulse_rest();
      send_rx(8'h10);
      send_rx(8'h20);
      send_rx(8'h31);
      wait_done(ok, acc_ok);
      repeat (5) tick();
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL csum_err: got %b, expected 1", err);
      end
      n_checks++;
      if (wr_a.size() - wb !== 2) begin
         n_fail++;
         $display("FAIL csum_wcount: got %0d strobes, expected 2", wr_a.size() - wb);
      end else begin
         n_checks++;
         if ({wr_a[wb], wr_d[wb], wr_a[wb + 1], wr_d[wb + 1]} !== 48'h9000_10_9001_20) begin
            n_fail++;
            $display("FAIL csum_writes: got %h, expected 900010900120",
                     {wr_a[wb], wr_d[wb], wr_a[wb + 1], wr_d[wb + 1]});
         end
      end
   endtask
`endif

   initial begin
      reset_n    = 1'b0;
      cfg_we     = 1'b0;
      cfg_idx    = 3'd0;
      cfg_start  = 16'h0000;
      cfg_len    = 8'd0;
      start_save = 1'b0;
      start_rest = 1'b0;
      tx_ready   = 1'b0;
      rx_data    = 8'h00;
      rx_valid   = 1'b0;

      test_reset();
      test_save_basic();
      test_restore_wrap();
      test_stall();
      test_start_conflict();
      test_reset_mid();
`ifdef HS_CHECKSUM_EN
      test_checksum();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
